// File: rtl/dac_refresh_scheduler.sv
// Sweeps every routed analog line through the DAC/router handshake and
// arbitrates direct single-line writes into the same path at slot boundaries.
module dac_refresh_scheduler #(
  parameter int VECTOR_SIZE    = 4,
  parameter int TOTAL_OPTIONS  = VECTOR_SIZE*2 + VECTOR_SIZE*VECTOR_SIZE,
  parameter int ADDR_WIDTH     = $clog2(TOTAL_OPTIONS),
  parameter int DATA_WIDTH     = 8,
  parameter int REFRESH_PERIOD = 1024,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_sweep_start,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ack,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [DATA_WIDTH-1:0] o_dac_code,
  output logic                  o_dac_data_valid,
  output logic [ADDR_WIDTH-1:0] o_addr_out,
  output logic                  o_addr_ready,
  input  logic                  i_router_ack,
  input  logic                  i_err_clr,
  output logic [1:0]            o_err,
  output logic                  o_busy,
  output logic                  o_sweep_done
);

  localparam int TIMER_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int WAIT_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MEM_RD   = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  logic [2:0]            state_reg, state_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic                  sweep_pending_reg, sweep_pending_next;
  logic                  sweep_active_reg, sweep_active_next;
  logic [ADDR_WIDTH-1:0] slot_reg, slot_next;
  logic                  is_write_reg, is_write_next;
  logic [WAIT_W-1:0]     wait_reg, wait_next;
  logic                  rel_cnt_reg, rel_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_out_reg, addr_out_next;
  logic [DATA_WIDTH-1:0] dac_code_reg, dac_code_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic                  wr_ack_reg, wr_ack_next;
  logic                  done_reg, done_next;
  logic [1:0]            err_reg, err_next;
  logic                  rd_en_reg, ready_reg, busy_reg;

  logic                  timer_wrap, pending_clr, wr_take, wr_in_range;
  logic                  arb_en, arb_sweep;
  logic [ADDR_WIDTH-1:0] arb_slot;
  logic [1:0]            err_set;

  // A write is not re-taken while its own ack is on the wire.
  assign wr_take     = i_wr_req && !wr_ack_reg;
  assign wr_in_range = {1'b0, i_wr_addr} < (ADDR_WIDTH+1)'(TOTAL_OPTIONS);

  always_comb begin
    timer_wrap = 1'b0;
    timer_next = timer_reg;
    if (i_enable) begin
      if (timer_reg == TIMER_W'(REFRESH_PERIOD - 1)) begin
        timer_next = '0;
        timer_wrap = 1'b1;
      end else begin
        timer_next = timer_reg + TIMER_W'(1);
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    sweep_active_next = sweep_active_reg;
    slot_next         = slot_reg;
    is_write_next     = is_write_reg;
    wait_next         = wait_reg;
    rel_cnt_next      = rel_cnt_reg;
    addr_out_next     = addr_out_reg;
    dac_code_next     = dac_code_reg;
    rd_addr_next      = rd_addr_reg;
    wr_ack_next       = 1'b0;
    done_next         = 1'b0;
    err_set           = 2'b00;
    pending_clr       = 1'b0;
    arb_en            = 1'b0;
    arb_sweep         = 1'b0;
    arb_slot          = slot_reg;

    case (state_reg)
      S_IDLE: begin
        arb_en    = 1'b1;
        arb_sweep = sweep_pending_reg;
      end
      S_MEM_RD: state_next = S_MEM_WAIT;
      S_MEM_WAIT: begin
        dac_code_next = i_mem_rd_data;
        addr_out_next = slot_reg;
        wait_next     = '0;
        state_next    = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_router_ack || wait_reg == WAIT_W'(ACK_TIMEOUT - 1)) begin
          err_set[0]   = !i_router_ack;
          wr_ack_next  = is_write_reg;
          rel_cnt_next = 1'b0;
          state_next   = S_RELEASE;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_RELEASE: begin
        rel_cnt_next = 1'b1;
        if (rel_cnt_reg) state_next = S_NEXT;
      end
      S_NEXT: begin
        // A finished write leaves the saved slot index untouched.
        if (is_write_reg) begin
          is_write_next = 1'b0;
          arb_en        = 1'b1;
          arb_sweep     = sweep_active_reg;
        end else if (slot_reg == ADDR_WIDTH'(TOTAL_OPTIONS - 1)) begin
          slot_next         = '0;
          done_next         = 1'b1;
          sweep_active_next = 1'b0;
          state_next        = S_IDLE;
        end else begin
          slot_next = slot_reg + ADDR_WIDTH'(1);
          arb_en    = 1'b1;
          arb_sweep = 1'b1;
          arb_slot  = slot_reg + ADDR_WIDTH'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (arb_en) begin
      if (wr_take && wr_in_range) begin
        is_write_next = 1'b1;
        addr_out_next = i_wr_addr;
        dac_code_next = i_wr_data;
        wait_next     = '0;
        state_next    = S_ISSUE;
      end else begin
        if (wr_take) begin
          wr_ack_next = 1'b1;
          err_set[1]  = 1'b1;
        end
        if (arb_sweep) begin
          state_next        = S_MEM_RD;
          rd_addr_next      = arb_slot;
          sweep_active_next = 1'b1;
          pending_clr       = (state_reg == S_IDLE);
        end else begin
          state_next = S_IDLE;
        end
      end
    end
  end

  assign sweep_pending_next = (sweep_pending_reg && !pending_clr) || timer_wrap || i_sweep_start;
  assign err_next           = (i_err_clr ? 2'b00 : err_reg) | err_set;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg         <= S_IDLE;
      timer_reg         <= '0;
      sweep_pending_reg <= 1'b0;
      sweep_active_reg  <= 1'b0;
      slot_reg          <= '0;
      is_write_reg      <= 1'b0;
      wait_reg          <= '0;
      rel_cnt_reg       <= 1'b0;
      addr_out_reg      <= '0;
      dac_code_reg      <= '0;
      rd_addr_reg       <= '0;
      wr_ack_reg        <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 2'b00;
      rd_en_reg         <= 1'b0;
      ready_reg         <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      sweep_pending_reg <= sweep_pending_next;
      sweep_active_reg  <= sweep_active_next;
      slot_reg          <= slot_next;
      is_write_reg      <= is_write_next;
      wait_reg          <= wait_next;
      rel_cnt_reg       <= rel_cnt_next;
      addr_out_reg      <= addr_out_next;
      dac_code_reg      <= dac_code_next;
      rd_addr_reg       <= rd_addr_next;
      wr_ack_reg        <= wr_ack_next;
      done_reg          <= done_next;
      err_reg           <= err_next;
      rd_en_reg         <= (state_next == S_MEM_RD);
      ready_reg         <= (state_next == S_ISSUE);
      busy_reg          <= (state_next != S_IDLE);
    end
  end

  assign o_wr_ack         = wr_ack_reg;
  assign o_mem_rd_en      = rd_en_reg;
  assign o_mem_rd_addr    = rd_addr_reg;
  assign o_dac_code       = dac_code_reg;
  assign o_dac_data_valid = ready_reg;
  assign o_addr_out       = addr_out_reg;
  assign o_addr_ready     = ready_reg;
  assign o_err            = err_reg;
  assign o_busy           = busy_reg;
  assign o_sweep_done     = done_reg;

endmodule

// File: tb/tb_dac_refresh_scheduler.sv
// Directed scenarios with random memory contents and write data, checked
// against transaction lists and cycle counts derived from the scheduling rules.
module tb_dac_refresh_scheduler;
  localparam int TOT = 24;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int RP  = 64;
  localparam int AT  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst, i_enable, i_sweep_start, i_wr_req, i_router_ack, i_err_clr;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data, mem_rd_data;
  logic          o_wr_ack, o_mem_rd_en, o_dac_data_valid, o_addr_ready, o_busy, o_sweep_done;
  logic [AW-1:0] o_mem_rd_addr, o_addr_out;
  logic [DW-1:0] o_dac_code;
  logic [1:0]    o_err;

  dac_refresh_scheduler #(.VECTOR_SIZE(4), .REFRESH_PERIOD(RP), .ACK_TIMEOUT(AT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_sweep_start(i_sweep_start),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_data(mem_rd_data),
    .o_dac_code(o_dac_code), .o_dac_data_valid(o_dac_data_valid), .o_addr_out(o_addr_out),
    .o_addr_ready(o_addr_ready), .i_router_ack(i_router_ack), .i_err_clr(i_err_clr),
    .o_err(o_err), .o_busy(o_busy), .o_sweep_done(o_sweep_done)
  );

  // Weight memory: one-cycle read latency.
  logic [DW-1:0] mem [TOT];
  always @(posedge clk) if (o_mem_rd_en) mem_rd_data <= mem[o_mem_rd_addr];

  int tests = 0, fails = 0, cyc = 0;
  int ack_delay = 2, no_ack_addr = -1;
  int issue_cnt = 0, to_len = 0, stable_err = 0;
  int iss_addr, iss_code;
  int done_cnt = 0, done_cyc = 0, wr_ack_cnt = 0, wr_ack_cyc = 0, wr_rtr_cyc = 0, ready_seen = 0;
  int rd0_q[$];
  int obs_a[$], obs_c[$], exp_a[$], exp_c[$];

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then play router and requester.
  task automatic step();
    @(negedge clk);
    cyc++;
    i_sweep_start = 1'b0;
    i_err_clr     = 1'b0;
    if (o_mem_rd_en && o_mem_rd_addr == 0) rd0_q.push_back(cyc);
    if (o_sweep_done) begin done_cnt++; done_cyc = cyc; end
    if (o_wr_ack) begin wr_ack_cnt++; wr_ack_cyc = cyc; i_wr_req = 1'b0; end
    if (o_dac_data_valid !== o_addr_ready) stable_err++;
    if (o_addr_ready) begin
      ready_seen++;
      issue_cnt++;
      if (issue_cnt == 1) begin
        iss_addr = int'(o_addr_out);
        iss_code = int'(o_dac_code);
      end else if (int'(o_addr_out) != iss_addr || int'(o_dac_code) != iss_code) begin
        stable_err++;
      end
      if (issue_cnt == ack_delay && int'(o_addr_out) != no_ack_addr) begin
        i_router_ack = 1'b1;
        obs_a.push_back(int'(o_addr_out));
        obs_c.push_back(int'(o_dac_code));
        if (i_wr_req) wr_rtr_cyc = cyc;
      end else begin
        i_router_ack = 1'b0;
      end
    end else begin
      if (issue_cnt > 0 && iss_addr == no_ack_addr) to_len = issue_cnt;
      issue_cnt    = 0;
      i_router_ack = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int n = 0; n < budget && done_cnt == d0; n++) step();
    check("sweep_done_seen", int'(done_cnt > d0), 1);
  endtask

  task automatic compare_txns(input string tag);
    int n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    check({tag, "_count"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, obs_a[i], exp_a[i]);
      check({tag, "_code"}, obs_c[i], exp_c[i]);
    end
    obs_a.delete(); obs_c.delete(); exp_a.delete(); exp_c.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ack"}, int'(o_wr_ack), 0);
    check({tag, "_rd_en"}, int'(o_mem_rd_en), 0);
    check({tag, "_rd_addr"}, int'(o_mem_rd_addr), 0);
    check({tag, "_dac_code"}, int'(o_dac_code), 0);
    check({tag, "_valid"}, int'(o_dac_data_valid), 0);
    check({tag, "_addr_out"}, int'(o_addr_out), 0);
    check({tag, "_addr_ready"}, int'(o_addr_ready), 0);
    check({tag, "_err"}, int'(o_err), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_sweep_done"}, int'(o_sweep_done), 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < TOT; i++) mem[i] = DW'($urandom_range(0, 255));
  endtask

  initial begin
    int t0, t1, t2, req_cyc, d0, wa, wd;
    i_rst = 1'b1; i_enable = 1'b0; i_sweep_start = 1'b0; i_wr_req = 1'b0;
    i_wr_addr = '0; i_wr_data = '0; i_router_ack = 1'b0; i_err_clr = 1'b0;
    randomize_mem();
    repeat (3) step();
    check_all_zero("reset");
    i_rst = 1'b0;
    step();

    // Full sweep, ack on the second ISSUE cycle: 7 cycles per slot.
    rd0_q.delete(); obs_a.delete(); obs_c.delete();
    i_sweep_start = 1'b1;
    wait_done(400);
    for (int i = 0; i < TOT; i++) begin exp_a.push_back(i); exp_c.push_back(int'(mem[i])); end
    compare_txns("sweep");
    t0 = (rd0_q.size() > 0) ? rd0_q[0] : -10000;
    check("sweep_length", done_cyc - t0, TOT * 7);
    step();
    check("sweep_idle_busy", int'(o_busy), 0);
    $display("[TB] sweep: %0d slots, length %0d cycles", TOT, done_cyc - t0);

    // Write arrives while slot 9 is in ISSUE; sweep resumes at slot 10.
    randomize_mem();
    wr_ack_cnt = 0;
    i_sweep_start = 1'b1;
    for (int n = 0; n < 300 && !(o_addr_ready && o_addr_out == 9); n++) step();
    check("slot9_reached", int'(o_addr_ready && o_addr_out == 9), 1);
    i_wr_req = 1'b1; i_wr_addr = 5'd5; i_wr_data = 8'hA5;
    wait_done(600);
    for (int i = 0; i < TOT; i++) begin
      exp_a.push_back(i); exp_c.push_back(int'(mem[i]));
      if (i == 9) begin exp_a.push_back(5); exp_c.push_back(8'hA5); end
    end
    compare_txns("sweep_with_write");
    check("mid_write_ack_count", wr_ack_cnt, 1);
    check("mid_write_ack_latency", wr_ack_cyc - wr_rtr_cyc, 1);
    $display("[TB] write during sweep: ack count %0d", wr_ack_cnt);

    // Out-of-range write: ack next cycle, error bit 1, no DAC cycle.
    repeat (2) step();
    wr_ack_cnt = 0; ready_seen = 0; req_cyc = cyc;
    i_wr_req = 1'b1; i_wr_addr = 5'd30; i_wr_data = DW'($urandom);
    repeat (4) step();
    check("bad_write_ack_count", wr_ack_cnt, 1);
    check("bad_write_ack_latency", wr_ack_cyc - req_cyc, 1);
    check("bad_write_err", int'(o_err), 2);
    check("bad_write_no_ready", ready_seen, 0);
    i_err_clr = 1'b1;
    repeat (2) step();
    check("err_clear", int'(o_err), 0);
    $display("[TB] out-of-range write: ack after %0d cycle(s)", wr_ack_cyc - req_cyc);

    // Idle writes with random target, code and router delay.
    for (int k = 0; k < 3; k++) begin
      ack_delay = $urandom_range(1, 4);
      wa = $urandom_range(0, TOT - 1);
      wd = $urandom_range(0, 255);
      wr_ack_cnt = 0; req_cyc = cyc;
      i_wr_req = 1'b1; i_wr_addr = AW'(wa); i_wr_data = DW'(wd);
      for (int n = 0; n < 50 && wr_ack_cnt == 0; n++) step();
      check("idle_write_ack_latency", wr_ack_cyc - req_cyc, 1 + ack_delay);
      repeat (4) step();
      exp_a.push_back(wa); exp_c.push_back(wd);
      compare_txns("idle_write");
      check("idle_write_busy", int'(o_busy), 0);
      $display("[TB] idle write addr %0d code %0d delay %0d", wa, wd, ack_delay);
    end

    // Router never acks slot 3: timeout after 255 ISSUE cycles, slot skipped.
    ack_delay = 2; no_ack_addr = 3; to_len = 0;
    i_sweep_start = 1'b1;
    wait_done(1500);
    for (int i = 0; i < TOT; i++)
      if (i != 3) begin exp_a.push_back(i); exp_c.push_back(int'(mem[i])); end
    compare_txns("timeout_sweep");
    check("timeout_issue_len", to_len, AT);
    check("timeout_err", int'(o_err), 1);
    i_err_clr = 1'b1;
    repeat (2) step();
    check("timeout_err_clear", int'(o_err), 0);
    no_ack_addr = -1;
    $display("[TB] timeout: ISSUE held %0d cycles", to_len);

    // Two extra triggers during a sweep coalesce into one extra sweep.
    ack_delay = 1; d0 = done_cnt; rd0_q.delete();
    i_sweep_start = 1'b1;
    repeat (20) step();
    i_sweep_start = 1'b1;
    repeat (10) step();
    i_sweep_start = 1'b1;
    repeat (600) step();
    check("coalesce_sweeps", done_cnt - d0, 2);
    check("coalesce_starts", rd0_q.size(), 2);
    obs_a.delete(); obs_c.delete();
    $display("[TB] coalesce: %0d sweeps", done_cnt - d0);

    // Reset in the middle of ISSUE.
    ack_delay = 3;
    i_sweep_start = 1'b1;
    for (int n = 0; n < 50 && !o_addr_ready; n++) step();
    check("pre_reset_issue", int'(o_addr_ready), 1);
    i_rst = 1'b1;
    step();
    check_all_zero("mid_reset");
    obs_a.delete(); obs_c.delete();

    // Timer from zero: first sweep one cycle after the wrap, then a
    // back-to-back sweep from the wraps that landed during the first.
    i_rst = 1'b0; i_enable = 1'b1; ack_delay = 1;
    rd0_q.delete(); d0 = done_cnt; t0 = cyc;
    for (int n = 0; n < 200 && rd0_q.size() == 0; n++) step();
    check("timer_first_start", ((rd0_q.size() > 0) ? rd0_q[0] : -10000) - t0, RP + 1);
    t1 = (rd0_q.size() > 0) ? rd0_q[0] : -10000;
    for (int n = 0; n < 300 && rd0_q.size() < 2; n++) step();
    t2 = (rd0_q.size() > 1) ? rd0_q[1] : -10000;
    i_enable = 1'b0;
    check("timer_second_start", t2 - t1, TOT * 6 + 1);
    repeat (400) step();
    check("timer_sweep_count", done_cnt - d0, 2);
    check("timer_start_count", rd0_q.size(), 2);
    $display("[TB] timer: starts at +%0d and +%0d", t1 - t0, t2 - t0);

    check("issue_stability", stable_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
